// File: rtl/ula_muldiv_seq_if.sv
// Request/result bundle for the sequential multiply/divide unit.
// Latency: n/a (signal grouping only).
// Backpressure: stall from the unit; requests outside IDLE/DONE are dropped.
// Ports: start/controle/op_a/op_b (request), stall/done/erro/res_lo/res_hi (response).
interface ula_muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       controle;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             stall;
  logic             done;
  logic             erro;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;

  modport master (
    output start, controle, op_a, op_b,
    input  stall, done, erro, res_lo, res_hi
  );

  modport slave (
    input  start, controle, op_a, op_b,
    output stall, done, erro, res_lo, res_hi
  );
endinterface

// File: rtl/ula_muldiv_seq.sv
// Sequential unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// Latency: done WIDTH+1 cycles after accept; 1 cycle for divide-by-zero.
// Backpressure: stall is high while accepting or running; start during RUN is ignored.
// Ports: clk, rst (sync, active-high); bus = slave side of ula_muldiv_seq_if
//   (start/controle/op_a/op_b in; stall/done/erro/res_lo/res_hi out).
module ula_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  ula_muldiv_seq_if.slave   bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic [WIDTH-1:0] opnd;     // multiplicand (mult) or divisor (div)
  logic [WIDTH-1:0] acc_hi;   // partial product high / partial remainder
  logic [WIDTH-1:0] acc_lo;   // multiplier bits / dividend bits -> quotient
  logic [WIDTH-1:0] nxt_hi, nxt_lo;
  logic [WIDTH-1:0] res_lo_q, res_hi_q;
  logic             erro_q;

  logic code_ok, can_take, accept, div_zero, last_iter;

  assign code_ok   = (bus.controle == 5'd2) || (bus.controle == 5'd3);
  assign can_take  = (state == IDLE) || (state == DONE);
  assign accept    = !rst && bus.start && code_ok && can_take;
  assign div_zero  = (bus.controle == 5'd3) && (bus.op_b == '0);
  assign last_iter = (cnt == CW'(WIDTH - 1));

  assign bus.stall  = !rst && ((state == RUN) || accept);
  assign bus.done   = (state == DONE);
  assign bus.erro   = erro_q;
  assign bus.res_lo = res_lo_q;
  assign bus.res_hi = res_hi_q;

  // One iteration of either algorithm.
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    rem_sh = {acc_hi, acc_lo[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, opnd});
    // When ge holds the true difference is below opnd, so WIDTH bits suffice.
    diff   = rem_sh[WIDTH-1:0] - opnd;
    if (is_div) begin
      nxt_hi = ge ? diff : rem_sh[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], ge};
    end else begin
      // Carry of the add shifts into the high word; its LSB into the low word.
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = div_zero ? DONE : RUN;
        else        state_nxt = IDLE;
      end
      RUN:     if (last_iter) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      opnd     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      erro_q   <= 1'b0;
    end else begin
      erro_q <= bus.start && !code_ok && can_take;
      if (accept) begin
        is_div <= (bus.controle == 5'd3);
        opnd   <= (bus.controle == 5'd3) ? bus.op_b : bus.op_a;
        acc_lo <= (bus.controle == 5'd3) ? bus.op_a : bus.op_b;
        acc_hi <= '0;
        cnt    <= '0;
        if (div_zero) begin
          res_lo_q <= '1;
          res_hi_q <= bus.op_a;
        end
      end else if (state == RUN) begin
        acc_hi <= nxt_hi;
        acc_lo <= nxt_lo;
        cnt    <= cnt + CW'(1);
        // Results are published only when the last iteration completes.
        if (last_iter) begin
          res_lo_q <= nxt_lo;
          res_hi_q <= nxt_hi;
        end
      end
    end
  end
endmodule

// File: tb/tb_ula_muldiv_seq.sv
module tb_ula_muldiv_seq;
  localparam int W = 32;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  ula_muldiv_seq_if #(.WIDTH(W)) bus ();

  ula_muldiv_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts negedges after the call until done; lat=-1 if the budget expires.
  task automatic wait_done(output int lat, output int stall_n, output int erro_n);
    lat = -1;
    stall_n = 0;
    erro_n = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (bus.erro) erro_n++;
      if (bus.done) begin
        lat = k;
        break;
      end
      if (bus.stall) stall_n++;
    end
  endtask

  // Drive a request at a negedge, report combinational stall, consume the accept edge.
  task automatic issue(input logic [4:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit keep_start, output logic stall_seen);
    @(negedge clk);
    bus.start = 1'b1;
    bus.controle = ctl;
    bus.op_a = a;
    bus.op_b = b;
    #1 stall_seen = bus.stall;
    @(posedge clk);
    #1;
    if (!keep_start) bus.start = 1'b0;
    bus.op_a = 32'hDEAD_BEEF;
    bus.op_b = 32'h1234_5678;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b1;
    bus.controle = 5'd2;
    bus.op_a = 7;
    bus.op_b = 6;
    @(negedge clk);
    n_cmp++;
    if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", bus.stall); end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0 || bus.erro !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags done=%b erro=%b want 0/0", bus.done, bus.erro);
    end
    n_cmp++;
    if (bus.res_lo !== '0 || bus.res_hi !== '0) begin
      n_bad++; $display("FAIL reset_res got %h/%h want 0/0", bus.res_hi, bus.res_lo);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.stall !== 1'b0 || bus.done !== 1'b0) begin
      n_bad++; $display("FAIL reset_idle stall=%b done=%b want 0/0", bus.stall, bus.done);
    end
  endtask

  task automatic test_mult;
    logic s;
    int lat, st, er;
    issue(5'd2, 7, 6, 1'b0, s);
    n_cmp++;
    if (s !== 1'b1) begin n_bad++; $display("FAIL mult_accept_stall got %b want 1", s); end
    wait_done(lat, st, er);
    n_cmp++;
    if (lat != 33) begin n_bad++; $display("FAIL mult_latency got %0d want 33", lat); end
    n_cmp++;
    if (st + 1 != 33) begin n_bad++; $display("FAIL mult_stall_cycles got %0d want 33", st + 1); end
    n_cmp++;
    if (bus.res_lo !== 32'd42 || bus.res_hi !== 32'd0) begin
      n_bad++; $display("FAIL mult_7x6 got %h/%h want 0/2a", bus.res_hi, bus.res_lo);
    end
    n_cmp++;
    if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL mult_done_stall got %b want 0", bus.stall); end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0 || bus.res_lo !== 32'd42) begin
      n_bad++; $display("FAIL mult_done_pulse done=%b res_lo=%h want 0/2a", bus.done, bus.res_lo);
    end

    issue(5'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, s);
    wait_done(lat, st, er);
    n_cmp++;
    if (lat != 33 || bus.res_hi !== 32'hFFFF_FFFE || bus.res_lo !== 32'h0000_0001) begin
      n_bad++; $display("FAIL mult_max lat=%0d got %h/%h want 33 fffffffe/00000001", lat, bus.res_hi, bus.res_lo);
    end
  endtask

  task automatic test_div;
    logic s;
    int lat, st, er;
    issue(5'd3, 100, 7, 1'b0, s);
    wait_done(lat, st, er);
    n_cmp++;
    if (lat != 33 || bus.res_lo !== 32'd14 || bus.res_hi !== 32'd2) begin
      n_bad++; $display("FAIL div_100_7 lat=%0d got q=%0d r=%0d want 33 14 2", lat, bus.res_lo, bus.res_hi);
    end
    issue(5'd3, 5, 0, 1'b0, s);
    n_cmp++;
    if (s !== 1'b1) begin n_bad++; $display("FAIL divz_accept_stall got %b want 1", s); end
    wait_done(lat, st, er);
    n_cmp++;
    if (lat != 1 || bus.res_lo !== 32'hFFFF_FFFF || bus.res_hi !== 32'd5) begin
      n_bad++; $display("FAIL div_by_zero lat=%0d got %h/%h want 1 00000005/ffffffff", lat, bus.res_hi, bus.res_lo);
    end
  endtask

  task automatic test_erro;
    logic s;
    issue(5'd0, 123, 456, 1'b0, s);
    n_cmp++;
    if (s !== 1'b0) begin n_bad++; $display("FAIL erro_stall got %b want 0", s); end
    @(negedge clk);
    n_cmp++;
    if (bus.erro !== 1'b1 || bus.done !== 1'b0) begin
      n_bad++; $display("FAIL erro_pulse erro=%b done=%b want 1/0", bus.erro, bus.done);
    end
    n_cmp++;
    if (bus.res_lo !== 32'hFFFF_FFFF || bus.res_hi !== 32'd5) begin
      n_bad++; $display("FAIL erro_res_held got %h/%h want 00000005/ffffffff", bus.res_hi, bus.res_lo);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.erro !== 1'b0 || bus.stall !== 1'b0) begin
      n_bad++; $display("FAIL erro_one_cycle erro=%b stall=%b want 0/0", bus.erro, bus.stall);
    end
  endtask

  task automatic test_start_in_run;
    logic s;
    int lat, er;
    issue(5'd2, 10, 10, 1'b0, s);
    lat = -1;
    er = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (bus.erro) er++;
      if (bus.done) begin lat = k; break; end
      if (k == 5)  begin bus.start = 1'b1; bus.controle = 5'd3; bus.op_a = 9; bus.op_b = 3; end
      if (k == 6)  bus.start = 1'b0;
      if (k == 10) begin bus.start = 1'b1; bus.controle = 5'd0; end
      if (k == 11) bus.start = 1'b0;
    end
    n_cmp++;
    if (lat != 33 || er != 0) begin
      n_bad++; $display("FAIL run_ignore lat=%0d erro_cnt=%0d want 33/0", lat, er);
    end
    n_cmp++;
    if (bus.res_lo !== 32'd100 || bus.res_hi !== 32'd0) begin
      n_bad++; $display("FAIL run_ignore_res got %h/%h want 0/64", bus.res_hi, bus.res_lo);
    end
  endtask

  task automatic test_back_to_back;
    logic s;
    int lat, st, er;
    issue(5'd2, 3, 4, 1'b1, s);
    bus.controle = 5'd3;
    bus.op_a = 9;
    bus.op_b = 2;
    wait_done(lat, st, er);
    n_cmp++;
    if (lat != 33 || bus.res_lo !== 32'd12 || bus.res_hi !== 32'd0) begin
      n_bad++; $display("FAIL b2b_first lat=%0d got %h/%h want 33 0/c", lat, bus.res_hi, bus.res_lo);
    end
    n_cmp++;
    if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL b2b_accept_in_done stall=%b want 1", bus.stall); end
    @(posedge clk);
    #1 bus.start = 1'b0;
    n_cmp++;
    if (bus.done !== 1'b0 || bus.res_lo !== 32'd12) begin
      n_bad++; $display("FAIL b2b_no_gap done=%b res_lo=%h want 0/c", bus.done, bus.res_lo);
    end
    // Second accept was the edge just consumed, so 33 more negedges reach N+66.
    wait_done(lat, st, er);
    n_cmp++;
    if (lat != 33 || bus.res_lo !== 32'd4 || bus.res_hi !== 32'd1) begin
      n_bad++; $display("FAIL b2b_second lat=%0d got q=%0d r=%0d want 33 4 1", lat, bus.res_lo, bus.res_hi);
    end
  endtask

  task automatic test_reset_mid_run;
    logic s;
    int lat, st, er, seen;
    issue(5'd2, 32'h0001_0000, 32'h0000_0300, 1'b0, s);
    for (int k = 0; k < 11; k++) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL rst_run_stall got %b want 0", bus.stall); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0 || bus.stall !== 1'b0 || bus.erro !== 1'b0 ||
        bus.res_lo !== '0 || bus.res_hi !== '0) begin
      n_bad++; $display("FAIL rst_run_state done=%b stall=%b erro=%b res=%h/%h want all 0",
                        bus.done, bus.stall, bus.erro, bus.res_hi, bus.res_lo);
    end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_bad++; $display("FAIL rst_run_no_done got %0d pulses want 0", seen); end
    issue(5'd2, 2, 3, 1'b0, s);
    wait_done(lat, st, er);
    n_cmp++;
    if (lat != 33 || bus.res_lo !== 32'd6 || bus.res_hi !== 32'd0) begin
      n_bad++; $display("FAIL rst_then_mult lat=%0d got %h/%h want 33 0/6", lat, bus.res_hi, bus.res_lo);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.controle = 5'd0;
    bus.op_a = '0;
    bus.op_b = '0;
    test_reset();
    test_mult();
    test_div();
    test_erro();
    test_start_in_run();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
